// File: rtl/sram_tile_reader_pkg.sv
// Shared types and default constants for the SRAM tile reader and its SRAM-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_tile_reader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DEPTH_DEF      = 2048;

    // Output buffer depth; the read issue logic never lets reads in flight exceed it.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Address increment that wraps back to 0 at the end of the addressable range.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned limit);
        return (addr + 1 >= limit) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/sram_tile_reader_if.sv
// Control, SRAM read port and output stream bundle of the tile reader.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer side; everything else is free-running.
interface sram_tile_reader_if
    import sram_tile_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_adr;
    logic [ADDR_WIDTH-1:0] length;
    logic                  busy;
    logic                  done;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] radr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Reader side.
    modport slave (
        input  start, base_adr, length, rdata, out_ready,
        output busy, done, ren, radr, out_data, out_valid, out_last
    );

    // Requester / SRAM / consumer side.
    modport master (
        output start, base_adr, length, rdata, out_ready,
        input  busy, done, ren, radr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ram_sync_1rw1r.sv
// Two-bank synchronous SRAM model: one read/write port and one read-only port.
// Latency: 1 cycle from enable to read data; read data holds while the port is idle.
// Backpressure: none; every enabled access completes.
module ram_sync_1rw1r
    import sram_tile_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  i_a_en,
    input  logic                  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_adr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_en,
    input  logic [ADDR_WIDTH-1:0] i_b_adr,
    output logic [DATA_WIDTH-1:0] o_b_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:2*DEPTH-1];
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

    // Both banks form one flat array; port A writes or reads, port B only reads.
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            if (i_a_we) r_mem[i_a_adr] <= i_a_wdata;
            else        r_a_rdata      <= r_mem[i_a_adr];
        end
        if (i_b_en) r_b_rdata <= r_mem[i_b_adr];
    end
endmodule

// File: rtl/sync_fifo_4.sv
// Four-entry synchronous FIFO holding streamed words with their last flag.
// Latency: 1 cycle from push to visible head.
// Backpressure: push while full and pop while empty are ignored; the writer must respect count.
module sync_fifo_4
    import sram_tile_reader_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic [FIFO_PW:0] o_count
);
    logic [WIDTH-1:0]   r_mem [0:FIFO_DEPTH-1];
    logic [FIFO_PW-1:0] r_wr_ptr;
    logic [FIFO_PW-1:0] r_rd_ptr;
    logic [FIFO_PW:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push     = i_push && (r_count != (FIFO_PW+1)'(FIFO_DEPTH));
    assign w_pop      = i_pop && (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + FIFO_PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_PW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/sram_tile_reader.sv
// Streams a tile of consecutive SRAM words (wrapping at the top of both banks) to a ready/valid consumer.
// Latency: READ entered the cycle after start; first word valid two cycles later, then one word per cycle.
// Backpressure: out_ready stalls the FIFO head; reads issue only while buffered + in-flight words stay below 4.
module sram_tile_reader
    import sram_tile_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_tile_reader_if.slave  bus
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_left;
    logic [ADDR_WIDTH-1:0] r_radr;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_accept_start;
    logic                  w_zero_start;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_fin;
    logic                  w_fifo_empty;
    logic [FIFO_PW:0]      w_fifo_count;
    logic [DATA_WIDTH:0]   w_head;

    assign w_accept_start = (r_state == ST_IDLE) && bus.start;
    assign w_zero_start   = w_accept_start && (bus.length == '0);
    // Room is judged on registered occupancy only, so issue never waits on out_ready combinationally.
    assign w_room         = (w_fifo_count + {{FIFO_PW{1'b0}}, r_inflight}) < (FIFO_PW+1)'(FIFO_DEPTH);
    assign w_issue        = (r_state == ST_READ) && w_room;
    assign w_issue_last   = w_issue && (r_left == ADDR_WIDTH'(1));
    assign w_pop          = !w_fifo_empty && bus.out_ready;
    assign w_fin          = (r_state == ST_DRAIN) && w_pop && w_head[DATA_WIDTH];
    assign w_addr_nxt     = ADDR_WIDTH'(wrap_inc(32'(r_addr), 2 * DEPTH));

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.ren       = w_issue;
    assign bus.radr      = w_issue ? r_addr : r_radr;
    assign bus.out_valid = !w_fifo_empty;
    assign bus.out_data  = w_head[DATA_WIDTH-1:0];
    // Stale last flags can sit in an empty slot, so the flag is gated by valid.
    assign bus.out_last  = !w_fifo_empty && w_head[DATA_WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: leave READ when the final read issues, leave DRAIN when the final word is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start && (bus.length != '0)) w_state_nxt = ST_READ;
            ST_READ:  if (w_issue_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fin) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Tile bookkeeping: address/remaining count, the one-deep read pipeline and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_left          <= '0;
            r_radr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= w_fin || w_zero_start;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_accept_start) begin
                r_addr <= bus.base_adr;
                r_left <= bus.length;
            end else if (w_issue) begin
                r_radr <= r_addr;
                r_addr <= w_addr_nxt;
                r_left <= r_left - ADDR_WIDTH'(1);
            end
        end
    end

    // Each returned word is buffered together with its last flag.
    sync_fifo_4 #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (r_inflight),
        .i_push_dat ({r_inflight_last, bus.rdata}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );
endmodule

// File: tb/tb_sram_tile_reader.sv
// Bench for sram_tile_reader attached to a ram_sync_1rw1r loaded with addr ^ 16'hA5A5.
// Latency: n/a.
// Backpressure: out_ready driven always-high, toggling or random depending on the phase.
module tb_sram_tile_reader;
    import sram_tile_reader_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        a_en, a_we;
    logic [11:0] a_adr;
    logic [15:0] a_wdata, a_rdata;
    int          rmode;
    int          n_checks = 0;
    int          n_fail   = 0;

    sram_tile_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

    sram_tile_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ram_sync_1rw1r #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(2048)) u_ram (
        .clk       (clk),
        .i_a_en    (a_en),
        .i_a_we    (a_we),
        .i_a_adr   (a_adr),
        .i_a_wdata (a_wdata),
        .o_a_rdata (a_rdata),
        .i_b_en    (bus.ren),
        .i_b_adr   (bus.radr),
        .o_b_rdata (bus.rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: every address holds its own value xor A5A5, addresses wrap at 4096.
    function automatic logic [15:0] exp_word(input int a);
        return 16'(a % 4096) ^ 16'hA5A5;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [16:0] exp_q[$];   // {last, data} words the consumer still has to see
    logic [15:0] got_q[$];   // words accepted so far, in order
    bit          m_active, m_done_pend, was_active, p_stall;
    int          m_iss_left, m_iss_addr, m_outst;
    logic [11:0] m_last_radr;
    logic [16:0] p_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_active = 0; m_done_pend = 0; m_iss_left = 0; m_iss_addr = 0;
            m_outst = 0; m_last_radr = '0; p_stall = 0;
        end else begin
            was_active = m_active;
            chk("busy", bus.busy, m_active);
            chk("done", bus.done, m_done_pend);
            m_done_pend = 0;
            chk("ren_allowed", bus.ren && (m_iss_left == 0), 0);
            if (bus.ren) begin
                m_outst++;
                if (m_iss_left > 0) begin
                    chk("radr", bus.radr, m_iss_addr);
                    m_last_radr = 12'(m_iss_addr);
                    m_iss_addr  = (m_iss_addr + 1) % 4096;
                    m_iss_left--;
                end
            end else begin
                chk("radr_hold", bus.radr, m_last_radr);
            end
            chk("outstanding_le_4", m_outst <= 4, 1);
            if (p_stall) chk("stall_stable", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, p_word});
            chk("valid_allowed", bus.out_valid && (exp_q.size() == 0), 0);
            if (bus.out_valid && exp_q.size() > 0) begin
                chk("out_data", bus.out_data, exp_q[0][15:0]);
                chk("out_last", bus.out_last, exp_q[0][16]);
                if (bus.out_ready) begin
                    got_q.push_back(bus.out_data);
                    if (exp_q[0][16]) begin
                        m_active    = 0;
                        m_done_pend = 1;
                    end
                    void'(exp_q.pop_front());
                    m_outst--;
                end
            end else if (!bus.out_valid) begin
                chk("out_last_idle", bus.out_last, 0);
            end
            p_stall = bus.out_valid && !bus.out_ready;
            p_word  = {bus.out_last, bus.out_data};
            if (bus.start && !was_active) begin
                if (bus.length == 0) begin
                    m_done_pend = 1;
                end else begin
                    m_active   = 1;
                    m_iss_addr = int'(bus.base_adr);
                    m_iss_left = int'(bus.length);
                    for (int k = 0; k < int'(bus.length); k++)
                        exp_q.push_back({k == int'(bus.length) - 1, exp_word(int'(bus.base_adr) + k)});
                end
            end
        end
    end

    // ---------------- consumer ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- directed sequence ----------------
    task automatic pulse_start(input int b, input int l);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_adr = 12'(b); bus.length = 12'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // k counts negedges after pulse_start returns; k=1 is the first cycle in READ.
    task automatic wait_done(input int maxc, output int first_v, output int done_k);
        first_v = -1;
        done_k  = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (bus.out_valid && first_v < 0) first_v = k;
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
        chk("done_timeout", done_k > 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_ren"}, bus.ren, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_radr"}, bus.radr, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
    endtask

    initial begin
        int fv, dk, g0, b, l;
        rst_n = 1'b0; rmode = 0;
        bus.start = 1'b0; bus.base_adr = '0; bus.length = '0;
        a_en = 1'b0; a_we = 1'b0; a_adr = '0; a_wdata = '0;
        #3;
        check_zero("reset");

        // Hand-computed values that pin the model's memory image and wrap.
        chk("pin_w0", exp_word(0), 16'hA5A5);
        chk("pin_w4094", exp_word(4094), 16'hAA5B);
        chk("pin_w4095", exp_word(4095), 16'hAA5A);
        chk("pin_wrap", exp_word(4096 + 1), 16'hA5A4);

        for (int a = 0; a < 4096; a++) begin
            @(posedge clk); #1;
            a_en = 1'b1; a_we = 1'b1; a_adr = 12'(a); a_wdata = 16'(a) ^ 16'hA5A5;
        end
        @(posedge clk); #1;
        a_we = 1'b0; a_adr = 12'h123;
        @(posedge clk); #1;
        a_en = 1'b0;
        chk("ram_readback", a_rdata, 16'hA486);
        rst_n = 1'b1;

        // Longest tile a 12-bit length allows, consumer always ready.
        g0 = got_q.size();
        pulse_start(0, 4095);
        wait_done(5000, fv, dk);
        chk("full_first_valid", fv, 3);
        chk("full_done_cycle", dk, 4095 + 3);
        chk("full_count", got_q.size() - g0, 4095);

        // Tile crossing the top of the address space.
        g0 = got_q.size();
        pulse_start(4094, 4);
        wait_done(100, fv, dk);
        chk("wrap_done_cycle", dk, 7);
        chk("wrap_count", got_q.size() - g0, 4);
        if (got_q.size() - g0 == 4) begin
            chk("wrap_w0", got_q[g0], 16'hAA5B);
            chk("wrap_w1", got_q[g0 + 1], 16'hAA5A);
            chk("wrap_w2", got_q[g0 + 2], 16'hA5A5);
            chk("wrap_w3", got_q[g0 + 3], 16'hA5A4);
        end

        // Consumer stalls every other cycle.
        rmode = 1;
        g0 = got_q.size();
        pulse_start(200, 16);
        wait_done(300, fv, dk);
        chk("toggle_count", got_q.size() - g0, 16);
        rmode = 0;

        // Zero-length tile.
        g0 = got_q.size();
        pulse_start(50, 0);
        wait_done(10, fv, dk);
        chk("zero_done_cycle", dk, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_ren", bus.ren, 0);
        repeat (4) @(negedge clk);
        chk("zero_count", got_q.size() - g0, 0);

        // Reset in the middle of a tile, then a short tile.
        pulse_start(0, 100);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_valid", bus.out_valid, 0);
        g0 = got_q.size();
        pulse_start(8, 2);
        wait_done(50, fv, dk);
        chk("after_reset_count", got_q.size() - g0, 2);
        if (got_q.size() - g0 == 2) begin
            chk("after_reset_w0", got_q[g0], 16'hA5AD);
            chk("after_reset_w1", got_q[g0 + 1], 16'hA5AC);
        end

        // A second start during a transfer must be ignored.
        g0 = got_q.size();
        pulse_start(100, 20);
        repeat (3) @(posedge clk);
        pulse_start(2000, 7);
        wait_done(200, fv, dk);
        chk("ignored_count", got_q.size() - g0, 20);
        if (got_q.size() - g0 == 20) begin
            chk("ignored_first", got_q[g0], exp_word(100));
            chk("ignored_last", got_q[g0 + 19], exp_word(119));
        end

        // Random tiles with a random consumer.
        rmode = 2;
        for (int t = 0; t < 12; t++) begin
            b = int'($urandom_range(0, 4095));
            l = int'($urandom_range(1, 40));
            g0 = got_q.size();
            pulse_start(b, l);
            wait_done(1000, fv, dk);
            chk("rand_count", got_q.size() - g0, l);
        end
        rmode = 0;

        repeat (5) @(negedge clk);
        chk("model_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
